// File: rtl/ex_stage.sv
// Execute stage: operand muxes, ALU, branch resolve and 1-cycle result register.
// Also holds the shared config package and the ALU.
package pkg_config;
  localparam int DATA_WIDTH = 32;
  localparam logic [5:0] OP_ALU_ADD  = 6'd0;
  localparam logic [5:0] OP_ALU_SUB  = 6'd1;
  localparam logic [5:0] OP_ALU_SLL  = 6'd2;
  localparam logic [5:0] OP_ALU_SLT  = 6'd3;
  localparam logic [5:0] OP_ALU_SLTU = 6'd4;
  localparam logic [5:0] OP_ALU_XOR  = 6'd5;
  localparam logic [5:0] OP_ALU_SRL  = 6'd6;
  localparam logic [5:0] OP_ALU_SRA  = 6'd7;
  localparam logic [5:0] OP_ALU_OR   = 6'd8;
  localparam logic [5:0] OP_ALU_AND  = 6'd9;
endpackage

module alu #(
  parameter int W = pkg_config::DATA_WIDTH
) (
  input  logic [5:0]   alu_op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o
);
  import pkg_config::*;
  localparam int SW = $clog2(W);

  logic [SW-1:0] sh;
  logic          lt_s;
  logic          lt_u;

  assign sh   = b_i[SW-1:0];
  assign lt_s = $signed(a_i) < $signed(b_i);
  assign lt_u = a_i < b_i;

  always_comb begin
    result_o = '0;
    unique case (1'b1)
      (alu_op_i == OP_ALU_ADD):  result_o = a_i + b_i;
      (alu_op_i == OP_ALU_SUB):  result_o = a_i - b_i;
      (alu_op_i == OP_ALU_SLL):  result_o = a_i << sh;
      (alu_op_i == OP_ALU_SLT):  result_o = {{(W-1){1'b0}}, lt_s};
      (alu_op_i == OP_ALU_SLTU): result_o = {{(W-1){1'b0}}, lt_u};
      (alu_op_i == OP_ALU_XOR):  result_o = a_i ^ b_i;
      (alu_op_i == OP_ALU_SRL):  result_o = a_i >> sh;
      (alu_op_i == OP_ALU_SRA):
        result_o = W'($signed(a_i) >>> sh);
      (alu_op_i == OP_ALU_OR):   result_o = a_i | b_i;
      (alu_op_i == OP_ALU_AND):  result_o = a_i & b_i;
      default:                   result_o = '0;
    endcase
  end
endmodule

module ex_stage #(
  parameter int DATA_WIDTH = pkg_config::DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [DATA_WIDTH-1:0] id_pc_i,
  input  logic [DATA_WIDTH-1:0] id_rs1_i,
  input  logic [DATA_WIDTH-1:0] id_rs2_i,
  input  logic [DATA_WIDTH-1:0] id_imm_i,
  input  logic [5:0]            id_alu_op_i,
  input  logic [1:0]            id_a_sel_i,
  input  logic                  id_b_sel_i,
  input  logic [2:0]            id_br_type_i,
  input  logic                  id_jalr_i,
  input  logic [4:0]            id_rd_i,
  input  logic                  id_rd_we_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [DATA_WIDTH-1:0] ex_result_o,
  output logic [DATA_WIDTH-1:0] ex_store_data_o,
  output logic [4:0]            ex_rd_o,
  output logic                  ex_rd_we_o,
  output logic                  redirect_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o
);
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] LSB0 =
    {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] tgt_base;
  logic [DATA_WIDTH-1:0] tgt_sum;
  logic [DATA_WIDTH-1:0] target;
  logic                  is_jump;
  logic                  taken;
  logic                  xfer;
  logic                  eq;
  logic                  lt_s;
  logic                  lt_u;

  assign id_ready_o = !ex_valid_o || ex_ready_i;
  assign xfer       = id_valid_i && id_ready_o;

  always_comb begin
    op_a = '0;
    unique case (id_a_sel_i)
      2'd0:    op_a = id_rs1_i;
      2'd1:    op_a = id_pc_i;
      default: op_a = '0;
    endcase
  end

  assign op_b = id_b_sel_i ? id_imm_i : id_rs2_i;

  alu #(.W(DATA_WIDTH)) u_alu (
    .alu_op_i (id_alu_op_i),
    .a_i      (op_a),
    .b_i      (op_b),
    .result_o (alu_res)
  );

  // Branch compare always sees raw rs1/rs2, not the muxed operands.
  assign eq   = id_rs1_i == id_rs2_i;
  assign lt_s = $signed(id_rs1_i) < $signed(id_rs2_i);
  assign lt_u = id_rs1_i < id_rs2_i;

  assign is_jump = id_br_type_i == 3'd7;

  always_comb begin
    taken = 1'b0;
    unique case (id_br_type_i)
      3'd1:    taken = eq;
      3'd2:    taken = !eq;
      3'd3:    taken = lt_s;
      3'd4:    taken = !lt_s;
      3'd5:    taken = lt_u;
      3'd6:    taken = !lt_u;
      3'd7:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign tgt_base = (is_jump && id_jalr_i) ? id_rs1_i : id_pc_i;
  assign tgt_sum  = tgt_base + id_imm_i;
  assign target   = (is_jump && id_jalr_i) ? (tgt_sum & LSB0)
                                           : tgt_sum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_o <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (xfer) begin
      ex_valid_o <= 1'b1;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_result_o     <= '0;
      ex_store_data_o <= '0;
      ex_rd_o         <= '0;
      ex_rd_we_o      <= 1'b0;
    end else if (xfer) begin
      ex_result_o     <= is_jump ? (id_pc_i + FOUR) : alu_res;
      ex_store_data_o <= id_rs2_i;
      ex_rd_o         <= id_rd_i;
      ex_rd_we_o      <= id_rd_we_i;
    end
  end

  // Redirect is a pulse: it can only rise on an accept edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else if (xfer && taken && !flush_i) begin
      redirect_o    <= 1'b1;
      redirect_pc_o <= target;
    end else begin
      redirect_o    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_ex_stage;
  localparam int W = 32;
  typedef logic [W-1:0] w_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_ready;
  w_t         pc, rs1, rs2, imm;
  logic [5:0] op;
  logic [1:0] a_sel;
  logic       b_sel;
  logic [2:0] br;
  logic       jalr;
  logic [4:0] rd;
  logic       rd_we, flush;
  logic       ex_valid, ex_ready;
  w_t         res, sdata, rpc;
  logic [4:0] ex_rd;
  logic       ex_rd_we, redir;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_stage #(.DATA_WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_pc_i(pc), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_imm_i(imm), .id_alu_op_i(op),
    .id_a_sel_i(a_sel), .id_b_sel_i(b_sel),
    .id_br_type_i(br), .id_jalr_i(jalr),
    .id_rd_i(rd), .id_rd_we_i(rd_we), .flush_i(flush),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .ex_result_o(res), .ex_store_data_o(sdata),
    .ex_rd_o(ex_rd), .ex_rd_we_o(ex_rd_we),
    .redirect_o(redir), .redirect_pc_o(rpc)
  );

  function automatic w_t ref_alu(int o, w_t a, w_t b);
    int sa = int'(a);
    int sb = int'(b);
    int s  = int'(b % 32);
    case (o)
      0: return w_t'(longint'(a) + longint'(b));
      1: return w_t'(longint'(a) - longint'(b));
      2: return w_t'(longint'(a) * (longint'(1) << s));
      3: return (sa < sb) ? 1 : 0;
      4: return (longint'(a) < longint'(b)) ? 1 : 0;
      5: return a ^ b;
      6: return w_t'(longint'(a) / (longint'(1) << s));
      7: return w_t'(sa >>> s);
      8: return a | b;
      9: return a & b;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_taken(int t, w_t a, w_t b);
    longint sa = longint'(int'(a));
    longint sb = longint'(int'(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    case (t)
      1: return ua == ub;
      2: return ua != ub;
      3: return sa < sb;
      4: return sa >= sb;
      5: return ua < ub;
      6: return ua >= ub;
      7: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic idle();
    id_valid = 0; pc = 0; rs1 = 0; rs2 = 0; imm = 0;
    op = 0; a_sel = 0; b_sel = 0; br = 0; jalr = 0;
    rd = 0; rd_we = 0; flush = 0;
  endtask

  task automatic drive(w_t p, w_t r1, w_t r2, w_t im,
                       logic [5:0] o, logic [1:0] as,
                       logic bs, logic [2:0] bt, logic j);
    id_valid = 1; pc = p; rs1 = r1; rs2 = r2; imm = im;
    op = o; a_sel = as; b_sel = bs; br = bt; jalr = j;
    rd = 5'd3; rd_we = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); ex_ready = 1; rst_n = 0;
    #12;
    checks++;
    if ({ex_valid, redir, res, sdata, rpc, ex_rd, ex_rd_we} !== '0)
      begin
      failures++;
      $display("FAIL reset: v=%b r=%b res=%h sd=%h pc=%h rd=%h we=%b want all 0",
               ex_valid, redir, res, sdata, rpc, ex_rd, ex_rd_we);
    end
    @(negedge clk); rst_n = 1;
    step();
  endtask

  task automatic test_add();
    drive(0, 5, 7, 0, 6'd0, 0, 0, 0, 0);
    step(); idle();
    checks++;
    if (ex_valid !== 1 || res !== 12 || redir !== 0 ||
        sdata !== 7 || ex_rd !== 3 || ex_rd_we !== 1) begin
      failures++;
      $display("FAIL add: v=%b res=%0d r=%b sd=%0d want 1/12/0/7",
               ex_valid, res, redir, sdata);
    end
    step();
    checks++;
    if (ex_valid !== 0 || res !== 12) begin
      failures++;
      $display("FAIL drain: v=%b res=%0d want 0/12", ex_valid, res);
    end
  endtask

  task automatic test_auipc_lui();
    drive(32'h1000, 0, 0, 32'h2000, 6'd0, 1, 1, 0, 0);
    step();
    checks++;
    if (res !== 32'h3000) begin
      failures++;
      $display("FAIL auipc: res=%h want 3000", res);
    end
    a_sel = 2;
    step(); idle();
    checks++;
    if (res !== 32'h2000 || ex_valid !== 1) begin
      failures++;
      $display("FAIL lui: res=%h v=%b want 2000/1", res, ex_valid);
    end
  endtask

  task automatic test_branch();
    drive(32'h100, 32'hFFFF_FFFF, 1, 32'h20, 6'd0, 0, 0, 3, 0);
    step(); idle();
    checks++;
    if (redir !== 1 || rpc !== 32'h120) begin
      failures++;
      $display("FAIL blt: r=%b pc=%h want 1/120", redir, rpc);
    end
    step();
    checks++;
    if (redir !== 0) begin
      failures++;
      $display("FAIL blt_pulse: r=%b want 0", redir);
    end
    drive(32'h100, 32'hFFFF_FFFF, 1, 32'h20, 6'd0, 0, 0, 5, 0);
    step(); idle();
    checks++;
    if (redir !== 0 || ex_valid !== 1) begin
      failures++;
      $display("FAIL bltu: r=%b v=%b want 0/1", redir, ex_valid);
    end
    drive(32'h100, 4, 4, 32'h20, 6'd0, 0, 0, 0, 0);
    rd_we = 0;
    step(); idle();
    checks++;
    if (redir !== 0 || ex_valid !== 1 || ex_rd_we !== 0) begin
      failures++;
      $display("FAIL none_br: r=%b v=%b we=%b want 0/1/0",
               redir, ex_valid, ex_rd_we);
    end
  endtask

  task automatic test_jalr();
    drive(32'h400, 32'h2003, 0, 4, 6'd0, 0, 1, 7, 1);
    step(); idle();
    checks++;
    if (res !== 32'h404 || rpc !== 32'h2006 || redir !== 1) begin
      failures++;
      $display("FAIL jalr: res=%h pc=%h r=%b want 404/2006/1",
               res, rpc, redir);
    end
    drive(32'hFFFF_FFF0, 0, 0, 32'h20, 6'd0, 0, 1, 7, 0);
    step(); idle();
    ex_ready = 0;
    checks++;
    if (res !== 32'hFFFF_FFF4 || rpc !== 32'h10) begin
      failures++;
      $display("FAIL jal_wrap: res=%h pc=%h want fffffff4/10",
               res, rpc);
    end
    step();
    checks++;
    if (redir !== 0 || ex_valid !== 1) begin
      failures++;
      $display("FAIL stall_pulse: r=%b v=%b want 0/1",
               redir, ex_valid);
    end
    ex_ready = 1;
    step();
  endtask

  task automatic test_back_to_back();
    drive(0, 10, 3, 0, 6'd1, 0, 0, 0, 0);
    step();
    ex_ready = 0;
    drive(0, 8, 2, 0, 6'd9, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (id_ready !== 0 || ex_valid !== 1 || res !== 7 ||
          sdata !== 3) begin
        failures++;
        $display("FAIL stall%0d: rdy=%b v=%b res=%0d want 0/1/7",
                 i, id_ready, ex_valid, res);
      end
    end
    ex_ready = 1;
    #1;
    checks++;
    if (id_ready !== 1) begin
      failures++;
      $display("FAIL release_rdy: rdy=%b want 1", id_ready);
    end
    step(); idle();
    checks++;
    if (ex_valid !== 1 || res !== 0 || sdata !== 2) begin
      failures++;
      $display("FAIL release: v=%b res=%0d sd=%0d want 1/0/2",
               ex_valid, res, sdata);
    end
    step();
  endtask

  task automatic test_flush();
    drive(32'h200, 3, 3, 8, 6'd0, 0, 0, 1, 0);
    flush = 1;
    #1;
    checks++;
    if (id_ready !== 1) begin
      failures++;
      $display("FAIL flush_rdy: rdy=%b want 1", id_ready);
    end
    step(); idle();
    checks++;
    if (ex_valid !== 0 || redir !== 0) begin
      failures++;
      $display("FAIL flush: v=%b r=%b want 0/0", ex_valid, redir);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 2, 0, 6'd0, 0, 0, 7, 0);
    step(); idle();
    ex_ready = 0;
    step();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({ex_valid, redir, res, sdata, rpc, ex_rd, ex_rd_we} !== '0)
      begin
      failures++;
      $display("FAIL reset_mid: v=%b r=%b res=%h pc=%h want 0",
               ex_valid, redir, res, rpc);
    end
    @(negedge clk); rst_n = 1;
    drive(0, 20, 22, 0, 6'd0, 0, 0, 0, 0);
    step(); idle();
    checks++;
    if (ex_valid !== 1 || res !== 42) begin
      failures++;
      $display("FAIL post_reset: v=%b res=%0d want 1/42",
               ex_valid, res);
    end
    ex_ready = 1;
    step();
  endtask

  task automatic test_random();
    bit ev = 0;
    bit er = 0;
    w_t eres = 0, esd = 0, epc = 0;
    logic [4:0] erd = 0;
    bit ewe = 0;
    for (int c = 0; c < 400; c++) begin
      bit acc;
      w_t a, b;
      id_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      pc  = $urandom; rs1 = $urandom; imm = $urandom;
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : w_t'($urandom);
      op  = 6'($urandom_range(0, 9));
      a_sel = 2'($urandom); b_sel = 1'($urandom);
      br = 3'($urandom); jalr = 1'($urandom);
      rd = 5'($urandom); rd_we = 1'($urandom);
      #1;
      checks++;
      if (id_ready !== (!ev || ex_ready)) begin
        failures++;
        $display("FAIL rnd_rdy c=%0d: %b want %b",
                 c, id_ready, !ev || ex_ready);
      end
      acc = id_valid && (!ev || ex_ready);
      a = (a_sel == 0) ? rs1 : (a_sel == 1) ? pc : 0;
      b = b_sel ? imm : rs2;
      if (acc) begin
        eres = (br == 7) ? pc + 4 : ref_alu(op, a, b);
        esd = rs2; erd = rd; ewe = rd_we;
      end
      er = acc && !flush && ref_taken(br, rs1, rs2);
      if (er) begin
        if (br == 7 && jalr) epc = (rs1 + imm) & ~w_t'(1);
        else epc = pc + imm;
      end
      if (flush) ev = 0;
      else if (acc) ev = 1;
      else if (ex_ready) ev = 0;
      step();
      checks++;
      if (ex_valid !== ev || redir !== er ||
          (ev && {res, sdata, ex_rd, ex_rd_we} !==
                 {eres, esd, erd, ewe}) ||
          (er && rpc !== epc)) begin
        failures++;
        $display("FAIL rnd c=%0d: v=%b r=%b res=%h pc=%h want %b/%b/%h/%h",
                 c, ex_valid, redir, res, rpc, ev, er, eres, epc);
      end
    end
    idle(); ex_ready = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_auipc_lui();
    test_branch();
    test_jalr();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
